simon_core: RTL and testbench
=============================

# simon_core

Parametrised Simon Says game engine for the Tiny Tapeout top level. It generates a pseudo-random sequence over N_CH buttons/LEDs and plays it back with programmable timing. It then checks the player's replay, extending the sequence one step per completed round up to MAX_LEN. The top-level wrapper maps `btn` and `led` onto `ui_in`/`uo_out`, and `score`/status onto `uio_out`.

## Interface

- N_CH, 4, number of buttons/LEDs; legal values 2, 4, 8; CW = $clog2(N_CH)
- MAX_LEN, 16, steps needed to win; 2..32; LW = $clog2(MAX_LEN+1)
- TICK_DIV, 6000000, clock cycles per display phase (LED on or off); ≥ 2
- TIMEOUT_TICKS, 8, display-phase durations allowed between presses before a loss; ≥ 1
- SEED, 16'hACE1, LFSR reset value; must be nonzero

- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new game; honoured in IDLE, WIN, LOSE only
- btn  in  N_CH  button levels, already synchronised and debounced; 1 = pressed
- led  out  N_CH  LED drive
- score  out  LW  completed rounds in the current/last game
- busy  out  1  1 in every state except IDLE, WIN, LOSE
- win  out  1  1 while in WIN
- lose  out  1  1 while in LOSE

## Operation

- Reset values: state IDLE, led 0, score 0, busy 0, win 0, lose 0, len 0, pos 0, tick counter 0, LFSR = SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle from reset, independent of state.
- Sequence store: MAX_LEN × CW registers. Entries are never cleared; only entries below len are read.
- Press detect: `any_q` registers `|btn`. A press is a cycle where `|btn`=1 and `any_q`=0. The press is valid only if `btn` is one-hot; its index is the encoded bit.
- States:
  - IDLE: led 0. On `start` go to ADD with len=0 and score=0.
  - ADD: lasts 1 cycle. Writes seq[len] = lfsr[CW-1:0], sets len=len+1 and pos=0, then goes to SHOW_ON.
  - SHOW_ON: lasts TICK_DIV cycles. led = onehot(seq[pos]). Then goes to SHOW_OFF.
  - SHOW_OFF: lasts TICK_DIV cycles. led = 0. Then increments pos. If the new pos equals len, go to WAIT_IN with pos=0; otherwise go to SHOW_ON.
  - WAIT_IN: led = btn (echo).
    - Valid press with index == seq[pos] goes to WAIT_REL.
    - Non-one-hot press, or a wrong index, goes to LOSE.
    - Timeout goes to LOSE.
  - WAIT_REL: led = btn. Waits for `|btn`=0, then increments pos.
    - If the new pos is below len: go to WAIT_IN.
    - Else score = len. If len == MAX_LEN go to WIN; otherwise go to ADD.
  - WIN: led all ones; win=1. On `start` go to ADD with len=0 and score=0.
  - LOSE: led toggles between all ones and all zeros every TICK_DIV cycles, starting with all ones; lose=1. Score holds. On `start` go to ADD with len=0 and score=0.
- Timeout: a tick counter runs in WAIT_IN and is cleared on entry. Reaching TIMEOUT_TICKS×TICK_DIV cycles with no press forces LOSE.
- Button activity during SHOW_ON/SHOW_OFF is ignored. `any_q` still tracks during these states, so a button held into WAIT_IN does not register as a press.
- `start` while busy is ignored.
- `rst` in any state returns to IDLE on the next edge with all reset values. The sequence store is not required to clear.

## Timing

- State, led, score and flags are registered and update together on the clock edge.
- Phase counter clears on every state entry. Each SHOW phase is exactly TICK_DIV cycles.
- `start` sampled at edge t: ADD visible at t+1, first led pattern at t+2.
- Round with len L: ADD (1 cycle) + 2·L·TICK_DIV show cycles, then WAIT_IN.
- Press sampled at edge t: WAIT_REL or LOSE visible at t+1.
- Release sampled at edge t: the next state (WAIT_IN, ADD or WIN) is visible at t+1. Score updates in the same cycle.
- Simultaneous `rst` and `start`: `rst` wins.

## Test plan

- Reset, then idle for 100 cycles → led=0, score=0, busy/win/lose=0. No change without `start`.
- Set TICK_DIV=4 and pulse `start` → led is one-hot for exactly 4 cycles, then 0 for 4 cycles, then WAIT_IN. Replay that button → second round shows the first step unchanged, then a new step; score=1.
- Set MAX_LEN=3 and replay the observed pattern each round → after the third release: win=1, score=3, led all ones. `start` → busy=1, score=0.
- In round 2, press the wrong button on step 2 → lose=1 next cycle, score=1, led blinks with period 2·TICK_DIV.
- In WAIT_IN, press two buttons simultaneously → LOSE. Separately, set TIMEOUT_TICKS=2 and TICK_DIV=4 with no press → LOSE exactly 8 cycles after WAIT_IN entry.
- Assert `rst` mid-SHOW_ON → next cycle IDLE, led=0, score=0. `start` pulsed during SHOW or WAIT_IN → no effect.

Source files
------------

// File: rtl/simon_core.sv
// Simon Says game engine: LFSR-driven sequence generation, timed LED playback,
// and checking of the player's button replay with a per-press timeout.
module simon_core #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TICK_DIV      = 6000000,
  parameter int unsigned TIMEOUT_TICKS = 8,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [N_CH-1:0]                  btn,
  output logic [N_CH-1:0]                  led,
  output logic [$clog2(MAX_LEN+1)-1:0]     score,
  output logic                             busy,
  output logic                             win,
  output logic                             lose
);

  localparam int unsigned CW     = $clog2(N_CH);
  localparam int unsigned LW     = $clog2(MAX_LEN + 1);
  localparam int unsigned AW     = $clog2(MAX_LEN);
  localparam int unsigned TO_CYC = TIMEOUT_TICKS * TICK_DIV;
  localparam int unsigned CNTW   = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_WAIT_REL,
    ST_WIN,
    ST_LOSE
  } state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   led_q, led_d;
  logic [LW-1:0]     score_q, score_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     pos_q, pos_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [15:0]       lfsr_q;
  logic              any_q;
  logic              busy_q, win_q, lose_q;
  logic [CW-1:0]     seq_q [MAX_LEN];

  logic              any_now;
  logic              press;
  logic              press_ok;
  logic [CW-1:0]     press_idx;
  logic [LW-1:0]     pos_inc;
  logic              phase_end;
  logic              timeout;
  logic [CW-1:0]     seq_cur;
  logic [CW-1:0]     seq_nxt;
  logic              lfsr_fb;

  function automatic logic [N_CH-1:0] onehot(input logic [CW-1:0] idx);
    return N_CH'(1) << idx;
  endfunction

  assign any_now   = |btn;
  assign press     = any_now & ~any_q;
  assign press_ok  = any_now && ((btn & (btn - N_CH'(1))) == '0);
  assign pos_inc   = pos_q + LW'(1);
  assign phase_end = (cnt_q == CNTW'(TICK_DIV - 1));
  assign timeout   = (cnt_q == CNTW'(TO_CYC - 1));
  assign seq_cur   = seq_q[AW'(pos_q)];
  assign seq_nxt   = seq_q[AW'(pos_inc)];
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Priority-free encoder; only meaningful when btn is one-hot.
  always_comb begin
    press_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (btn[i]) press_idx = CW'(i);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    score_d = score_q;
    len_d   = len_q;
    pos_d   = pos_q;

    case (state_q)
      ST_IDLE: begin
        led_d = '0;
        if (start) begin
          state_d = ST_ADD;
          len_d   = '0;
          score_d = '0;
        end
      end

      ST_ADD: begin
        // The new entry lands at index len; it is shown first only when len is 0.
        len_d   = len_q + LW'(1);
        pos_d   = '0;
        state_d = ST_SHOW_ON;
        led_d   = onehot((len_q == '0) ? lfsr_q[CW-1:0] : seq_q[0]);
      end

      ST_SHOW_ON: begin
        if (phase_end) begin
          state_d = ST_SHOW_OFF;
          led_d   = '0;
        end
      end

      ST_SHOW_OFF: begin
        if (phase_end) begin
          if (pos_inc == len_q) begin
            state_d = ST_WAIT_IN;
            pos_d   = '0;
            led_d   = btn;
          end else begin
            state_d = ST_SHOW_ON;
            pos_d   = pos_inc;
            led_d   = onehot(seq_nxt);
          end
        end
      end

      ST_WAIT_IN: begin
        led_d = btn;
        if (press) begin
          if (press_ok && (press_idx == seq_cur)) begin
            state_d = ST_WAIT_REL;
          end else begin
            state_d = ST_LOSE;
            led_d   = '1;
          end
        end else if (timeout) begin
          state_d = ST_LOSE;
          led_d   = '1;
        end
      end

      ST_WAIT_REL: begin
        led_d = btn;
        if (!any_now) begin
          pos_d = pos_inc;
          if (pos_inc < len_q) begin
            state_d = ST_WAIT_IN;
          end else begin
            score_d = len_q;
            if (len_q == LW'(MAX_LEN)) begin
              state_d = ST_WIN;
              led_d   = '1;
            end else begin
              state_d = ST_ADD;
              led_d   = '0;
            end
          end
        end
      end

      ST_WIN: begin
        led_d = '1;
        if (start) begin
          state_d = ST_ADD;
          len_d   = '0;
          score_d = '0;
          led_d   = '0;
        end
      end

      ST_LOSE: begin
        if (phase_end) led_d = ~led_q;
        if (start) begin
          state_d = ST_ADD;
          len_d   = '0;
          score_d = '0;
          led_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        led_d   = '0;
      end
    endcase
  end

  // Phase counter: cleared on any state change, wraps every phase while blinking.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q) begin
      case (state_q)
        ST_SHOW_ON, ST_SHOW_OFF, ST_WAIT_IN: cnt_d = cnt_q + CNTW'(1);
        ST_LOSE:                             cnt_d = phase_end ? '0 : cnt_q + CNTW'(1);
        default:                             cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= '0;
      score_q <= '0;
      len_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      any_q   <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      score_q <= score_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
      any_q   <= any_now;
      busy_q  <= !(state_d inside {ST_IDLE, ST_WIN, ST_LOSE});
      win_q   <= (state_d == ST_WIN);
      lose_q  <= (state_d == ST_LOSE);
    end
  end

  // Sequence store is never cleared; stale entries above len are never read.
  always_ff @(posedge clk) begin
    if (state_q == ST_ADD) seq_q[AW'(len_q)] <= lfsr_q[CW-1:0];
  end

  assign led   = led_q;
  assign score = score_q;
  assign busy  = busy_q;
  assign win   = win_q;
  assign lose  = lose_q;

endmodule

// File: tb/tb_simon_core.sv
// Bench for simon_core: queue-based game model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_simon_core;

  localparam int unsigned N_CH          = 4;
  localparam int unsigned MAX_LEN       = 3;
  localparam int unsigned TICK_DIV      = 4;
  localparam int unsigned TIMEOUT_TICKS = 2;
  localparam logic [15:0] SEED          = 16'hACE1;
  localparam int unsigned LW            = $clog2(MAX_LEN + 1);
  localparam int          TO_CYC        = TIMEOUT_TICKS * TICK_DIV;

  localparam int M_IDLE = 0, M_ADD = 1, M_SHOW = 2, M_WAIT = 3,
                 M_REL  = 4, M_WIN = 5, M_LOSE = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] led;
  logic [LW-1:0]   score;
  logic            busy, win, lose;

  always #5 clk = ~clk;

  simon_core #(
    .N_CH(N_CH), .MAX_LEN(MAX_LEN), .TICK_DIV(TICK_DIV),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn),
    .led(led), .score(score), .busy(busy), .win(win), .lose(lose)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_mode   = M_IDLE;
  int              m_seq[$];
  int              m_show[$];
  int              m_score  = 0;
  int              m_pos    = 0;
  int              m_wait   = 0;
  int              m_lose_t = 0;
  bit              m_any    = 1'b0;
  bit              m_en     = 1'b0;
  logic [15:0]     m_lfsr   = SEED;
  logic [N_CH-1:0] m_led    = '0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    int unsigned v;
    int unsigned fb;
    v  = l;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  always @(posedge clk) begin : model
    int nb;
    bit pr;
    nb    = $countones(btn);
    pr    = (nb != 0) && !m_any;
    m_any = (nb != 0);
    if (rst) begin
      m_mode  = M_IDLE;
      m_led   = '0;
      m_score = 0;
      m_pos   = 0;
      m_any   = 1'b0;
      m_lfsr  = SEED;
      m_seq.delete();
      m_show.delete();
    end else begin
      case (m_mode)
        M_IDLE, M_WIN, M_LOSE: begin
          if (start) begin
            m_seq.delete();
            m_score = 0;
            m_mode  = M_ADD;
            m_led   = '0;
          end else if (m_mode == M_LOSE) begin
            m_lose_t++;
            m_led = ((m_lose_t / TICK_DIV) % 2 == 0) ? '1 : '0;
          end
        end
        M_ADD: begin
          m_seq.push_back(int'(m_lfsr) % N_CH);
          m_show.delete();
          foreach (m_seq[k]) begin
            repeat (TICK_DIV) m_show.push_back(1 << m_seq[k]);
            repeat (TICK_DIV) m_show.push_back(0);
          end
          m_led  = N_CH'(m_show.pop_front());
          m_mode = M_SHOW;
        end
        M_SHOW: begin
          if (m_show.size() == 0) begin
            m_mode = M_WAIT;
            m_pos  = 0;
            m_wait = 0;
            m_led  = btn;
          end else begin
            m_led = N_CH'(m_show.pop_front());
          end
        end
        M_WAIT: begin
          m_led = btn;
          if (pr) begin
            if (nb == 1 && btn == N_CH'(1 << m_seq[m_pos])) m_mode = M_REL;
            else begin
              m_mode = M_LOSE; m_lose_t = 0; m_led = '1;
            end
          end else begin
            m_wait++;
            if (m_wait == TO_CYC) begin
              m_mode = M_LOSE; m_lose_t = 0; m_led = '1;
            end
          end
        end
        M_REL: begin
          m_led = btn;
          if (nb == 0) begin
            m_pos++;
            if (m_pos < m_seq.size()) begin
              m_mode = M_WAIT;
              m_wait = 0;
            end else begin
              m_score = m_seq.size();
              if (m_score == MAX_LEN) begin
                m_mode = M_WIN; m_led = '1;
              end else begin
                m_mode = M_ADD; m_led = '0;
              end
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_en) begin
      check("led",   32'(led),   32'(m_led));
      check("score", 32'(score), 32'(m_score));
      check("busy",  32'(busy),  32'(m_mode inside {M_ADD, M_SHOW, M_WAIT, M_REL}));
      check("win",   32'(win),   32'(m_mode == M_WIN));
      check("lose",  32'(lose),  32'(m_mode == M_LOSE));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_mode(input int mode, input string tag);
    int n;
    n = 0;
    while (m_mode != mode && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (m_mode != mode) check({"wait_", tag}, 32'(m_mode), 32'(mode));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press_release(input logic [N_CH-1:0] b);
    btn = b;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
  endtask

  task automatic play_round();
    int n;
    wait_mode(M_WAIT, "round");
    n = m_seq.size();
    for (int k = 0; k < n; k++) begin
      wait_mode(M_WAIT, "step");
      press_release(N_CH'(1 << m_seq[m_pos]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    logic [N_CH-1:0] wrong;
    rst = 1'b1; start = 1'b0; btn = '0;
    @(negedge clk);
    m_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_led",  32'(led),  32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    repeat (100) @(negedge clk);
    check("idle_led",   32'(led),   32'h0);
    check("idle_score", 32'(score), 32'h0);
    check("idle_busy",  32'(busy),  32'h0);

    // Full game to WIN
    pulse_start();
    check("start_busy", 32'(busy), 32'h1);
    play_round();
    check("round1_score", 32'(score), 32'h1);
    play_round();
    play_round();
    check("win_flag",  32'(win),   32'h1);
    check("win_score", 32'(score), 32'h3);
    check("win_led",   32'(led),   32'hF);
    pulse_start();
    check("restart_busy",  32'(busy),  32'h1);
    check("restart_score", 32'(score), 32'h0);

    // Wrong button on step 2 of round 2
    play_round();
    wait_mode(M_WAIT, "r2s1");
    press_release(N_CH'(1 << m_seq[m_pos]));
    wait_mode(M_WAIT, "r2s2");
    wrong = N_CH'(1 << ((m_seq[1] + 1) % N_CH));
    btn = wrong;
    @(negedge clk);
    check("wrong_lose",  32'(lose),  32'h1);
    check("wrong_score", 32'(score), 32'h1);
    check("blink_on0",   32'(led),   32'hF);
    btn = '0;
    repeat (TICK_DIV) @(negedge clk);
    check("blink_off", 32'(led), 32'h0);
    repeat (TICK_DIV) @(negedge clk);
    check("blink_on1", 32'(led), 32'hF);

    // Two buttons at once
    pulse_start();
    wait_mode(M_WAIT, "multi");
    btn = 4'b0011;
    @(negedge clk);
    check("multi_lose", 32'(lose), 32'h1);
    btn = '0;

    // Timeout with no press
    pulse_start();
    wait_mode(M_WAIT, "timeout");
    n = 0;
    while (lose !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO_CYC));

    // start ignored while busy, then reset mid-show
    pulse_start();
    wait_mode(M_SHOW, "ign_show");
    pulse_start();
    wait_mode(M_WAIT, "ign_wait");
    pulse_start();
    press_release(N_CH'(1 << m_seq[m_pos]));
    wait_mode(M_SHOW, "rst_show");
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_led",   32'(led),   32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_add", 32'(busy), 32'h1);
    @(negedge clk);
    check("first_step_led", 32'(led), 32'h8);
    check("model_seq0", 32'(m_seq[0]), 32'h3);
    play_round();
    @(negedge clk);
    check("model_seq1", 32'(m_seq[1]), 32'h1);
    repeat (2 * TICK_DIV) @(negedge clk);
    check("second_step_led", 32'(led), 32'h2);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
